// File: rtl/mem_stage_dm_if.sv
// rtl/mem_stage_dm_if.sv - MEM-stage data memory access bundle
interface mem_stage_dm_if;
    logic        MemWriteM;
    logic [1:0]  StoreTypeM;
    logic [2:0]  LoadTypeM;
    logic [31:0] ALU_outM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        AddrErrM;
    logic [15:0] WriteCountM;

    modport master (
        output MemWriteM, StoreTypeM, LoadTypeM, ALU_outM, WriteDataM,
        input  ReadDataM, AddrErrM, WriteCountM
    );

    modport slave (
        input  MemWriteM, StoreTypeM, LoadTypeM, ALU_outM, WriteDataM,
        output ReadDataM, AddrErrM, WriteCountM
    );
endinterface

// File: rtl/mem_stage_dm.sv
// rtl/mem_stage_dm.sv - MEM-stage byte-lane data memory with load extension and address faults
module mem_stage_dm #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_BITS   = 10
) (
    input  logic           clk,
    input  logic           reset,
    mem_stage_dm_if.slave  bus
);
    localparam logic [1:0] ST_SW   = 2'b00;
    localparam logic [1:0] ST_SH   = 2'b01;
    localparam logic [1:0] ST_SB   = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;
    localparam logic [2:0] LD_LH   = 3'b001;
    localparam logic [2:0] LD_LHU  = 3'b010;
    localparam logic [2:0] LD_LB   = 3'b011;
    localparam logic [2:0] LD_LBU  = 3'b100;

    typedef enum logic [1:0] {W_WORD, W_HALF, W_BYTE} width_t;

    logic                 storeReq;
    width_t               accWidth;
    logic                 misaligned;
    logic                 outOfRange;
    logic                 addrErr;
    logic                 commit;
    logic [ADDR_BITS-1:0] wordIdx;
    logic [3:0]           byteEn;
    logic [31:0]          laneData;
    logic [31:0]          laneMask;
    logic [31:0]          rawWord;
    logic [15:0]          halfSel;
    logic [7:0]           byteSel;
    logic [31:0]          loadData;
    logic [15:0]          writeCount;
    logic [31:0]          wordQ [DEPTH_WORDS];

    assign wordIdx  = bus.ALU_outM[ADDR_BITS+1:2];
    // StoreTypeM=11 behaves exactly like no store, including which width is checked.
    assign storeReq = bus.MemWriteM && (bus.StoreTypeM != ST_NONE);

    always_comb begin
        accWidth = W_WORD;
        if (storeReq) begin
            case (bus.StoreTypeM)
                ST_SH:   accWidth = W_HALF;
                ST_SB:   accWidth = W_BYTE;
                default: accWidth = W_WORD;
            endcase
        end else begin
            case (bus.LoadTypeM)
                LD_LH, LD_LHU: accWidth = W_HALF;
                LD_LB, LD_LBU: accWidth = W_BYTE;
                default:       accWidth = W_WORD;
            endcase
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (accWidth)
            W_WORD:  misaligned = (bus.ALU_outM[1:0] != 2'b00);
            W_HALF:  misaligned = bus.ALU_outM[0];
            default: misaligned = 1'b0;
        endcase
    end

    assign outOfRange = |bus.ALU_outM[31:ADDR_BITS+2];
    assign addrErr    = misaligned || outOfRange;
    assign commit     = storeReq && !addrErr;

    always_comb begin
        byteEn   = 4'b0000;
        laneData = bus.WriteDataM;
        case (bus.StoreTypeM)
            ST_SW: byteEn = 4'b1111;
            ST_SH: begin
                byteEn   = bus.ALU_outM[1] ? 4'b1100 : 4'b0011;
                laneData = {2{bus.WriteDataM[15:0]}};
            end
            ST_SB: begin
                byteEn   = 4'b0001 << bus.ALU_outM[1:0];
                laneData = {4{bus.WriteDataM[7:0]}};
            end
            default: byteEn = 4'b0000;
        endcase
    end

    assign laneMask = {{8{byteEn[3]}}, {8{byteEn[2]}}, {8{byteEn[1]}}, {8{byteEn[0]}}};

    for (genvar w = 0; w < DEPTH_WORDS; w++) begin : g_word
        logic [31:0] word;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                word <= '0;
            end else if (commit && (wordIdx == ADDR_BITS'(w))) begin
                word <= (word & ~laneMask) | (laneData & laneMask);
            end
        end
        assign wordQ[w] = word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            writeCount <= '0;
        end else if (commit) begin
            writeCount <= writeCount + 16'd1;
        end
    end

    // Reads see the pre-edge word, so a same-cycle store is visible only next cycle.
    assign rawWord = reset ? wordQ[wordIdx] : '0;
    assign halfSel = bus.ALU_outM[1] ? rawWord[31:16] : rawWord[15:0];
    assign byteSel = rawWord[{bus.ALU_outM[1:0], 3'b000} +: 8];

    always_comb begin
        case (bus.LoadTypeM)
            LD_LH:   loadData = {{16{halfSel[15]}}, halfSel};
            LD_LHU:  loadData = {16'h0000, halfSel};
            LD_LB:   loadData = {{24{byteSel[7]}}, byteSel};
            LD_LBU:  loadData = {24'h000000, byteSel};
            default: loadData = rawWord;
        endcase
        if (addrErr) begin
            loadData = '0;
        end
    end

    assign bus.ReadDataM   = loadData;
    assign bus.AddrErrM    = addrErr;
    assign bus.WriteCountM = writeCount;
endmodule

// File: tb/tb_mem_stage_dm.sv
// tb/tb_mem_stage_dm.sv - scoreboard bench for mem_stage_dm
module tb_mem_stage_dm;
    localparam logic [1:0] SW = 2'b00, SH = 2'b01, SB = 2'b10, SNONE = 2'b11;
    localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011, LBU = 3'b100;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    exp_t        sbq[$];
    exp_t        e;
    int          nTests = 0;
    int          nFail  = 0;
    logic [15:0] expCount;

    always #5 clk = ~clk;

    mem_stage_dm_if bus ();

    mem_stage_dm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic drv(input logic we, input logic [1:0] st, input logic [2:0] lt,
                       input logic [31:0] a, input logic [31:0] d);
        bus.MemWriteM  = we;
        bus.StoreTypeM = st;
        bus.LoadTypeM  = lt;
        bus.ALU_outM   = a;
        bus.WriteDataM = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
        drv(1'b1, st, LW, a, d);
    endtask

    task automatic load(input string n, input logic [2:0] lt, input logic [31:0] a,
                        input logic [31:0] expData, input logic expErr);
        exp_t x;
        drv(1'b0, SNONE, lt, a, 32'h0);
        x.name = n;
        x.data = expData;
        x.err  = expErr;
        sbq.push_back(x);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        load("reset_lw", LW, 32'h10, 32'h0, 1'b0);
        @(negedge clk);
        e = sbq.pop_front(); nTests++;
        if (bus.ReadDataM !== e.data || bus.AddrErrM !== e.err) begin
            nFail++;
            $display("FAIL %s: data=%h err=%b, expected data=%h err=%b", e.name, bus.ReadDataM, bus.AddrErrM, e.data, e.err);
        end
        nTests++;
        if (bus.WriteCountM !== 16'h0000) begin
            nFail++;
            $display("FAIL reset_count: got %h, expected 0000", bus.WriteCountM);
        end
        reset    = 1'b1;
        expCount = 16'h0000;
    endtask

    task automatic test_word();
        step();
        store(SW, 32'h10, 32'hDEADBEEF);
        step();
        expCount++;
        load("word_lw", LW, 32'h10, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        e = sbq.pop_front(); nTests++;
        if (bus.ReadDataM !== e.data || bus.AddrErrM !== e.err) begin
            nFail++;
            $display("FAIL %s: data=%h err=%b, expected data=%h err=%b", e.name, bus.ReadDataM, bus.AddrErrM, e.data, e.err);
        end
        nTests++;
        if (bus.WriteCountM !== expCount) begin
            nFail++;
            $display("FAIL word_count: got %h, expected %h", bus.WriteCountM, expCount);
        end
    endtask

    task automatic test_byte();
        logic [2:0]  lts  [3] = '{LB, LBU, LW};
        logic [31:0] adrs [3] = '{32'h23, 32'h23, 32'h20};
        logic [31:0] exps [3] = '{32'hFFFFFF80, 32'h00000080, 32'h80000000};
        step();
        store(SB, 32'h23, 32'hFFFFFF80);
        step();
        expCount++;
        for (int i = 0; i < 3; i++) begin
            load($sformatf("byte_%0d", i), lts[i], adrs[i], exps[i], 1'b0);
            @(negedge clk);
            e = sbq.pop_front(); nTests++;
            if (bus.ReadDataM !== e.data || bus.AddrErrM !== e.err) begin
                nFail++;
                $display("FAIL %s: data=%h err=%b, expected data=%h err=%b", e.name, bus.ReadDataM, bus.AddrErrM, e.data, e.err);
            end
            step();
        end
    endtask

    task automatic test_half();
        logic [2:0]  lts  [3] = '{LH, LHU, LW};
        logic [31:0] adrs [3] = '{32'h32, 32'h32, 32'h30};
        logic [31:0] exps [3] = '{32'hFFFFABCD, 32'h0000ABCD, 32'hABCD0000};
        store(SH, 32'h32, 32'h1234ABCD);
        step();
        expCount++;
        for (int i = 0; i < 3; i++) begin
            load($sformatf("half_%0d", i), lts[i], adrs[i], exps[i], 1'b0);
            @(negedge clk);
            e = sbq.pop_front(); nTests++;
            if (bus.ReadDataM !== e.data || bus.AddrErrM !== e.err) begin
                nFail++;
                $display("FAIL %s: data=%h err=%b, expected data=%h err=%b", e.name, bus.ReadDataM, bus.AddrErrM, e.data, e.err);
            end
            step();
        end
    endtask

    task automatic test_faults();
        logic [2:0]  lts  [5] = '{LW, LW, LH, LB, LBU};
        logic [31:0] adrs [5] = '{32'h10, 32'h1000, 32'h31, 32'h31, 32'h33};
        logic [31:0] exps [5] = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h000000AB};
        logic        errs [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        store(SW, 32'h11, 32'h55555555);
        @(negedge clk);
        nTests++;
        if (bus.AddrErrM !== 1'b1) begin
            nFail++;
            $display("FAIL fault_sw_err: got %b, expected 1", bus.AddrErrM);
        end
        step();
        drv(1'b1, SNONE, LW, 32'h10, 32'hFFFFFFFF);
        step();
        drv(1'b1, SH, LW, 32'h33, 32'hFFFFFFFF);
        @(negedge clk);
        nTests++;
        if (bus.AddrErrM !== 1'b1) begin
            nFail++;
            $display("FAIL fault_sh_err: got %b, expected 1", bus.AddrErrM);
        end
        step();
        nTests++;
        if (bus.WriteCountM !== expCount) begin
            nFail++;
            $display("FAIL fault_count: got %h, expected %h", bus.WriteCountM, expCount);
        end
        for (int i = 0; i < 5; i++) begin
            load($sformatf("fault_%0d", i), lts[i], adrs[i], exps[i], errs[i]);
            @(negedge clk);
            e = sbq.pop_front(); nTests++;
            if (bus.ReadDataM !== e.data || bus.AddrErrM !== e.err) begin
                nFail++;
                $display("FAIL %s: data=%h err=%b, expected data=%h err=%b", e.name, bus.ReadDataM, bus.AddrErrM, e.data, e.err);
            end
            step();
        end
    endtask

    task automatic test_same_cycle();
        store(SW, 32'h40, 32'h11111111);
        step();
        expCount++;
        store(SW, 32'h40, 32'h22222222);
        e.name = "same_pre"; e.data = 32'h11111111; e.err = 1'b0;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front(); nTests++;
        if (bus.ReadDataM !== e.data || bus.AddrErrM !== e.err) begin
            nFail++;
            $display("FAIL %s: data=%h err=%b, expected data=%h err=%b", e.name, bus.ReadDataM, bus.AddrErrM, e.data, e.err);
        end
        step();
        expCount++;
        load("same_post", LW, 32'h40, 32'h22222222, 1'b0);
        @(negedge clk);
        e = sbq.pop_front(); nTests++;
        if (bus.ReadDataM !== e.data || bus.AddrErrM !== e.err) begin
            nFail++;
            $display("FAIL %s: data=%h err=%b, expected data=%h err=%b", e.name, bus.ReadDataM, bus.AddrErrM, e.data, e.err);
        end
        step();
    endtask

    task automatic test_async_reset();
        store(SW, 32'h50, 32'h5A5A5A5A);
        step();
        expCount++;
        load("arst_pre", LW, 32'h50, 32'h5A5A5A5A, 1'b0);
        @(negedge clk);
        e = sbq.pop_front(); nTests++;
        if (bus.ReadDataM !== e.data || bus.AddrErrM !== e.err) begin
            nFail++;
            $display("FAIL %s: data=%h err=%b, expected data=%h err=%b", e.name, bus.ReadDataM, bus.AddrErrM, e.data, e.err);
        end
        #2;
        reset    = 1'b0;
        expCount = 16'h0000;
        load("arst_lw", LW, 32'h10, 32'h0, 1'b0);
        #1;
        e = sbq.pop_front(); nTests++;
        if (bus.ReadDataM !== e.data || bus.AddrErrM !== e.err) begin
            nFail++;
            $display("FAIL %s: data=%h err=%b, expected data=%h err=%b", e.name, bus.ReadDataM, bus.AddrErrM, e.data, e.err);
        end
        nTests++;
        if (bus.WriteCountM !== expCount) begin
            nFail++;
            $display("FAIL arst_count: got %h, expected %h", bus.WriteCountM, expCount);
        end
        load("arst_err", LW, 32'h1001, 32'h0, 1'b1);
        #1;
        e = sbq.pop_front(); nTests++;
        if (bus.ReadDataM !== e.data || bus.AddrErrM !== e.err) begin
            nFail++;
            $display("FAIL %s: data=%h err=%b, expected data=%h err=%b", e.name, bus.ReadDataM, bus.AddrErrM, e.data, e.err);
        end
        store(SW, 32'h50, 32'hAAAAAAAA);
        step();
        load("arst_held", LW, 32'h50, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        e = sbq.pop_front(); nTests++;
        if (bus.ReadDataM !== e.data || bus.AddrErrM !== e.err) begin
            nFail++;
            $display("FAIL %s: data=%h err=%b, expected data=%h err=%b", e.name, bus.ReadDataM, bus.AddrErrM, e.data, e.err);
        end
        nTests++;
        if (bus.WriteCountM !== expCount) begin
            nFail++;
            $display("FAIL arst_held_count: got %h, expected %h", bus.WriteCountM, expCount);
        end
        step();
        store(SW, 32'h50, 32'hCAFEF00D);
        step();
        expCount++;
        load("arst_first", LW, 32'h50, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        e = sbq.pop_front(); nTests++;
        if (bus.ReadDataM !== e.data || bus.AddrErrM !== e.err) begin
            nFail++;
            $display("FAIL %s: data=%h err=%b, expected data=%h err=%b", e.name, bus.ReadDataM, bus.AddrErrM, e.data, e.err);
        end
        nTests++;
        if (bus.WriteCountM !== expCount) begin
            nFail++;
            $display("FAIL arst_first_count: got %h, expected %h", bus.WriteCountM, expCount);
        end
    endtask

    task automatic test_wrap();
        drv(1'b0, SNONE, LW, 32'h0, 32'h0);
        reset = 1'b0;
        #1;
        reset    = 1'b1;
        expCount = 16'h0000;
        store(SB, 32'h60, 32'h01);
        repeat (65535) begin
            @(posedge clk);
            expCount++;
        end
        #1;
        drv(1'b0, SNONE, LW, 32'h60, 32'h0);
        @(negedge clk);
        nTests++;
        if (bus.WriteCountM !== expCount) begin
            nFail++;
            $display("FAIL wrap_ffff: got %h, expected %h", bus.WriteCountM, expCount);
        end
        store(SB, 32'h61, 32'h02);
        step();
        expCount++;
        drv(1'b0, SNONE, LW, 32'h60, 32'h0);
        @(negedge clk);
        nTests++;
        if (bus.WriteCountM !== expCount) begin
            nFail++;
            $display("FAIL wrap_zero: got %h, expected %h", bus.WriteCountM, expCount);
        end
    endtask

    initial begin
        drv(1'b0, SNONE, LW, 32'h0, 32'h0);
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_faults();
        test_same_cycle();
        test_async_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
